// File: rtl/calc_disp_pkg.sv
// Shared definitions for the calculator display sequencer: character codes
// understood by the 7-segment character decoders, FSM states and range limits.
package calc_disp_pkg;

   localparam logic [3:0] CODE_R     = 4'hA;
   localparam logic [3:0] CODE_DASH  = 4'hB;
   localparam logic [3:0] CODE_BLANK = 4'hF;

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      FMT
   } state_t;

   // Largest magnitude a positive value may have on a display of 'digits' digits.
   function automatic logic [63:0] pos_limit(input int digits);
      logic [63:0] p;
      p = 64'd1;
      for (int i = 0; i < digits; i++) p = p * 64'd10;
      return p - 64'd1;
   endfunction

   // Largest magnitude a negative value may have: one digit goes to the minus sign.
   function automatic logic [63:0] neg_limit(input int digits);
      return pos_limit(digits - 1);
   endfunction

endpackage

// File: rtl/calc_display_ctrl_dd_step.sv
// One double-dabble iteration: every BCD nibble above 4 gets +3, then the
// whole {bcd, binary} vector shifts left by one. The BCD field occupies the
// top BCD_W bits; the bit shifted out of the top is discarded.
module dd_step
   import calc_disp_pkg::*;
#(
   parameter int W     = 32,
   parameter int BCD_W = 16
) (
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   logic [W-1:0] adj;

   // Per-nibble add-3 correction followed by the 1-bit shift.
   always_comb begin
      // NOTE: every variable written here gets a default first, so no latch is inferred.
      adj = din;
      for (int i = 0; i < BCD_W / 4; i++) begin
         if (din[W-BCD_W+4*i +: 4] > 4'd4)
            adj[W-BCD_W+4*i +: 4] = din[W-BCD_W+4*i +: 4] + 4'd3;
      end
      dout = {adj[W-2:0], 1'b0};
   end

endmodule

// File: rtl/calc_display_ctrl.sv
// Display sequencer: converts a signed result to per-digit character codes
// (double-dabble over VALUE_W cycles), then blanks leading zeros, places the
// minus sign, or shows the error pattern "-rr-".
module calc_display_ctrl
   import calc_disp_pkg::*;
#(
   parameter int DIGITS  = 4,
   parameter int VALUE_W = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [VALUE_W-1:0]    value_in,
   input  logic                  err_in,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   digit_codes
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int SR_W  = BCD_W + VALUE_W;
   localparam int CNT_W = $clog2(VALUE_W + 1);
   localparam logic [63:0] POS_LIM = pos_limit(DIGITS);
   localparam logic [63:0] NEG_LIM = neg_limit(DIGITS);

   state_t             state, state_nxt;
   logic [SR_W-1:0]    sr, sr_step;
   logic [CNT_W-1:0]   cnt;
   logic               neg_q, err_q;
   logic               accept;
   logic               in_neg, in_ovf;
   logic [VALUE_W-1:0] in_mag;
   logic [63:0]        mag_ext;
   logic [BCD_W-1:0]   bcd, blanked, fmt_codes;

   // done is high for the first IDLE cycle after FMT; a start there is dropped
   // so that only the cycle after done can launch the next conversion.
   assign accept = (state == IDLE) && start && !done;
   assign busy   = (state != IDLE);

   // Sign, magnitude and overflow classification of the incoming value.
   always_comb begin
      in_neg  = value_in[VALUE_W-1];
      in_mag  = in_neg ? -value_in : value_in;
      mag_ext = {{(64-VALUE_W){1'b0}}, in_mag};
      // The most-negative input negates to itself, so its magnitude MSB stays set.
      in_ovf  = err_in
              | (in_neg & in_mag[VALUE_W-1])
              | (!in_neg && (mag_ext > POS_LIM))
              | (in_neg && (mag_ext > NEG_LIM));
   end

   dd_step #(
      .W     (SR_W),
      .BCD_W (BCD_W)
   ) u_dd_step (
      .din  (sr),
      .dout (sr_step)
   );

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = in_ovf ? FMT : CONV;
         CONV:    if (cnt == CNT_W'(1)) state_nxt = FMT;
         FMT:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: capture on accept, shift during CONV, publish codes in FMT.
   always_ff @(posedge clk) begin
      if (reset) begin
         sr          <= '0;
         cnt         <= '0;
         neg_q       <= 1'b0;
         err_q       <= 1'b0;
         done        <= 1'b0;
         digit_codes <= {DIGITS{CODE_BLANK}};
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  neg_q <= in_neg;
                  err_q <= in_ovf;
                  sr    <= {{BCD_W{1'b0}}, in_mag};
                  cnt   <= CNT_W'(VALUE_W);
               end
            end
            CONV: begin
               sr  <= sr_step;
               cnt <= cnt - CNT_W'(1);
            end
            FMT: begin
               digit_codes <= fmt_codes;
               done        <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bcd = sr[SR_W-1 -: BCD_W];

   // Formatting: leading-zero blanking, minus placement, error pattern.
   always_comb begin
      logic lead;
      lead    = 1'b1;
      blanked = bcd;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         if (lead && (bcd[4*i +: 4] == 4'd0)) blanked[4*i +: 4] = CODE_BLANK;
         else                                 lead = 1'b0;
      end
      fmt_codes = blanked;
      // The dash goes just left of the most significant shown digit; the range
      // check guarantees that position exists for negative values.
      if (neg_q) begin
         for (int i = 0; i < DIGITS - 1; i++) begin
            if ((blanked[4*(i+1) +: 4] == CODE_BLANK) && (blanked[4*i +: 4] != CODE_BLANK))
               fmt_codes[4*(i+1) +: 4] = CODE_DASH;
         end
      end
      if (err_q) begin
         fmt_codes = {DIGITS{CODE_R}};
         fmt_codes[3:0]             = CODE_DASH;
         fmt_codes[BCD_W-1 -: 4]    = CODE_DASH;
      end
   end

endmodule

// File: tb/tb_calc_display_ctrl.sv
// Self-checking bench for calc_display_ctrl (DIGITS=4, VALUE_W=16). Expected
// codes and done cycles are pushed to a scoreboard when a start is accepted
// and popped when done is observed.
module tb_calc_display_ctrl;

   localparam int DIGITS  = 4;
   localparam int VALUE_W = 16;
   localparam int LAT_NORM = 17;   // accepting edge to done-visible edge
   localparam int LAT_ERR  = 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [15:0]   value_in;
   logic          err_in;
   logic          busy;
   logic          done;
   logic [15:0]   digit_codes;

   int cyc = 0;
   int n_pass = 0;
   int n_total = 0;

   typedef struct {
      logic [15:0] codes;
      int          at;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic [15:0] v;
      logic        e;
      logic [15:0] codes;
      int          lat;
   } vec_t;

   vec_t vecs[9] = '{
      '{16'd1234, 1'b0, 16'h1234, LAT_NORM},
      '{16'd0,    1'b0, 16'hFFF0, LAT_NORM},
      '{16'd9999, 1'b0, 16'h9999, LAT_NORM},
      '{16'hFFFB, 1'b0, 16'hFFB5, LAT_NORM},   // -5
      '{16'hFC19, 1'b0, 16'hB999, LAT_NORM},   // -999
      '{16'hFC18, 1'b0, 16'hBAAB, LAT_ERR},    // -1000
      '{16'd10000,1'b0, 16'hBAAB, LAT_ERR},
      '{16'd3,    1'b1, 16'hBAAB, LAT_ERR},
      '{16'h8000, 1'b0, 16'hBAAB, LAT_ERR}
   };

   calc_display_ctrl #(
      .DIGITS  (DIGITS),
      .VALUE_W (VALUE_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .value_in    (value_in),
      .err_in      (err_in),
      .busy        (busy),
      .done        (done),
      .digit_codes (digit_codes)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Drive one start; returns the edge count at which it was sampled.
   task automatic issue(input logic [15:0] v, input logic e, input logic [15:0] codes,
                        input int lat, input bit push, output int t_acc);
      @(negedge clk);
      start = 1'b1; value_in = v; err_in = e;
      @(posedge clk); #1;
      t_acc = cyc;
      start = 1'b0; err_in = 1'b0;
      if (push) sb.push_back('{codes, t_acc + lat});
   endtask

   // Wait (bounded) for done and compare against the scoreboard head.
   task automatic collect(input string name);
      exp_t e;
      bit   got = 0;
      bit   busy_ok = 1;
      for (int k = 0; k < 60 && !got; k++) begin
         @(negedge clk);
         if (done === 1'b1) got = 1;
         else if (busy !== 1'b1) busy_ok = 0;
      end
      n_total++;
      if (!got || sb.size() == 0) begin
         $display("FAIL %s done: got none/unexpected, required done within 60 cycles", name);
         if (sb.size() > 0) void'(sb.pop_front());
         return;
      end
      n_pass++;
      e = sb.pop_front();
      n_total++;
      if (digit_codes !== e.codes)
         $display("FAIL %s codes: got %h required %h", name, digit_codes, e.codes);
      else n_pass++;
      n_total++;
      if (cyc !== e.at)
         $display("FAIL %s latency: done at edge %0d required %0d", name, cyc, e.at);
      else n_pass++;
      n_total++;
      if (!busy_ok || busy !== 1'b0)
         $display("FAIL %s busy: busy_ok=%0d busy_at_done=%b required 1/0", name, busy_ok, busy);
      else n_pass++;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; value_in = '0; err_in = 1'b0;
      repeat (3) @(negedge clk);
      n_total++;
      if (busy !== 1'b0 || done !== 1'b0 || digit_codes !== 16'hFFFF)
         $display("FAIL reset_state: busy=%b done=%b codes=%h required 0 0 ffff", busy, done, digit_codes);
      else n_pass++;
      reset = 1'b0;
   endtask

   task automatic test_mid_reset();
      int t;
      issue(16'd1234, 1'b0, 16'h0000, LAT_NORM, 1'b0, t);
      @(negedge clk);
      while (cyc < t + 4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      n_total++;
      if (busy !== 1'b0 || done !== 1'b0 || digit_codes !== 16'hFFFF)
         $display("FAIL mid_reset: busy=%b done=%b codes=%h required 0 0 ffff", busy, done, digit_codes);
      else n_pass++;
      reset = 1'b0;
      issue(16'd7, 1'b0, 16'hFFF7, LAT_NORM, 1'b1, t);
      collect("after_reset_7");
   endtask

   task automatic test_values();
      int t;
      foreach (vecs[i]) begin
         issue(vecs[i].v, vecs[i].e, vecs[i].codes, vecs[i].lat, 1'b1, t);
         collect($sformatf("value_%h_err%0d", vecs[i].v, vecs[i].e));
      end
   endtask

   task automatic test_back_to_back();
      int   t, t2;
      bit   got = 0;
      exp_t e;
      issue(16'd42, 1'b0, 16'hFF42, LAT_NORM, 1'b1, t);
      for (int k = 0; k < 60 && !got; k++) begin
         @(negedge clk);
         if (done === 1'b1) got = 1;
         else begin
            start    = (cyc == t + 2) || (cyc == t + 9);
            value_in = 16'd77;
         end
      end
      start = 1'b0;
      n_total++;
      if (!got) begin
         $display("FAIL ignore_start done: got none, required done within 60 cycles");
         void'(sb.pop_front());
         return;
      end
      n_pass++;
      e = sb.pop_front();
      n_total++;
      if (digit_codes !== e.codes || cyc !== e.at)
         $display("FAIL ignore_start: codes=%h at %0d required %h at %0d", digit_codes, cyc, e.codes, e.at);
      else n_pass++;
      // start during the done cycle must be dropped
      start = 1'b1; value_in = 16'd5;
      @(negedge clk);
      n_total++;
      if (busy !== 1'b0 || done !== 1'b0)
         $display("FAIL start_in_done_cycle: busy=%b done=%b required 0 0", busy, done);
      else n_pass++;
      // held one more cycle: now accepted
      @(posedge clk); #1;
      t2 = cyc;
      start = 1'b0;
      sb.push_back('{16'hFFF5, t2 + LAT_NORM});
      collect("start_after_done");
   endtask

   initial begin
      test_reset();
      test_mid_reset();
      test_values();
      test_back_to_back();
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
